// File: rtl/multicore_sobel_keys_pio.sv
// multicore_sobel_keys_pio: debounced, edge-capturing Avalon-MM input PIO with a maskable level irq
// clk/reset: system clock, async active-high reset
// address/chipselect/write_n/writedata/readdata: Avalon-MM slave, 0 = data, 2 = irqmask, 3 = edgecapture (W1C)
// in_port: asynchronous key/switch inputs; irq: |(edgecapture & irqmask)
module multicore_sobel_keys_pio #(
  parameter int WIDTH = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [WIDTH-1:0] s1, s2, filt, filt_nxt, irqmask, edgecapture, edges, clr;
  logic wr, unused_ok;
  assign wr = chipselect & ~write_n;
  assign unused_ok = ^writedata;
  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign filt_nxt = s2;
    end else begin : g_deb
      localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
      localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CW-1:0] cnt;
        // the counter restarts whenever the synced input returns to the filtered value
        assign filt_nxt[i] = (s2[i] != filt[i] && cnt == CNT_MAX) ? s2[i] : filt[i];
        always_ff @(posedge clk or posedge reset)
          if (reset) cnt <= '0;
          else cnt <= (s2[i] == filt[i] || cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      end
    end
  endgenerate
  assign edges = EDGE_TYPE == 0 ? ~filt & filt_nxt :
                 EDGE_TYPE == 1 ? filt & ~filt_nxt : filt ^ filt_nxt;
  assign clr = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      filt <= '0;
      irqmask <= '0;
      edgecapture <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
      filt <= filt_nxt;
      irqmask <= (wr && address == 2'd2) ? writedata[WIDTH-1:0] : irqmask;
      edgecapture <= (edgecapture & ~clr) | edges;
    end
  always_comb
    readdata = !chipselect       ? '0 :
               address == 2'd0   ? 32'(filt) :
               address == 2'd2   ? 32'(irqmask) :
               address == 2'd3   ? 32'(edgecapture) : '0;
  assign irq = |(edgecapture & irqmask);
endmodule
